// File: rtl/uart_tx_byte.sv
// uart_tx_byte
//   Serial output stage for the converted character stream. Characters
//   arrive over a valid/ready handshake. They are buffered in a small
//   circular FIFO and sent on a single line as 8N1 UART frames: one start
//   bit, eight data bits LSB first, and one stop bit.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (2..65535)
//   FIFO_DEPTH   : input buffer entries (power of two, >= 2)
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   in_data  : character to send, captured when in_valid && in_ready
//   in_valid : upstream presents a character
//   in_ready : FIFO has room (not full)
//   tx       : registered serial line, idles high
//   busy     : FIFO non-empty or frame in progress
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Frame state
  state_t        r_state;
  logic          r_tx;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;

  // FIFO state
  logic [7:0]    r_fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Next-state and control wires
  state_t        w_state_nxt;
  logic          w_tx_nxt;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic          w_baud_last;
  logic [7:0]    w_head;

  assign w_fifo_empty = (r_count == {CW{1'b0}});
  assign w_fifo_full  = (r_count == COUNT_FULL);
  assign w_push       = in_valid && !w_fifo_full;
  assign w_head       = r_fifo_mem[r_rd_ptr];
  assign w_baud_last  = (r_baud == BAUD_LAST);

  assign in_ready = !w_fifo_full;
  assign tx       = r_tx;
  assign busy     = (r_state != S_IDLE) || !w_fifo_empty;

  // Next-state logic. tx is computed one step ahead so the registered line
  // already carries the new bit value in the first cycle of each bit.
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_nxt      = r_tx;
    w_baud_nxt    = r_baud;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_fifo_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_head;
          w_baud_nxt    = {BW{1'b0}};
          w_bit_idx_nxt = 3'd0;
          w_tx_nxt      = 1'b0;
          w_state_nxt   = S_START;
        end else begin
          w_baud_nxt = {BW{1'b0}};
        end
      end

      S_START: begin
        if (w_baud_last) begin
          w_baud_nxt    = {BW{1'b0}};
          w_bit_idx_nxt = 3'd0;
          w_tx_nxt      = r_shift[0];
          w_state_nxt   = S_DATA;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end

      S_DATA: begin
        if (w_baud_last) begin
          w_baud_nxt = {BW{1'b0}};
          if (r_bit_idx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            // Next bit on the line is the one that becomes shift[0].
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_tx_nxt      = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end

      S_STOP: begin
        if (w_baud_last) begin
          w_baud_nxt = {BW{1'b0}};
          // Chain straight into the next start bit when data is waiting.
          if (!w_fifo_empty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = w_head;
            w_bit_idx_nxt = 3'd0;
            w_tx_nxt      = 1'b0;
            w_state_nxt   = S_START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end

      default: begin
        w_tx_nxt    = 1'b1;
        w_baud_nxt  = {BW{1'b0}};
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame state registers; reset forces the line high immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_baud    <= {BW{1'b0}};
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // FIFO storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_byte.sv
module tb_uart_tx_byte;
  localparam int CPB = 4;
  localparam int FD  = 4;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;

  int n_tests;
  int n_fail;
  int cyc;

  // Line decoder output (reference view of what left the chip)
  logic [7:0] dec_q[$];
  int         low_q[$];
  int         start_q[$];
  int         frame_err;

  uart_tx_byte #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent 8N1 decoder sampling the line at each falling clock edge.
  initial begin : decoder
    bit         active;
    int         idx;
    int         lows;
    logic [7:0] b;
    active = 0; idx = 0; lows = 0; b = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1; idx = 0; lows = 1; b = 8'h00;
          start_q.push_back(cyc);
        end
      end else begin
        idx++;
        if (tx === 1'b0) lows++;
        if (idx >= CPB + CPB/2 && idx <= 8*CPB + CPB/2 && (idx % CPB) == CPB/2)
          b[(idx - CPB - CPB/2) / CPB] = tx;
        if (idx == 9*CPB + CPB/2 && tx !== 1'b1) frame_err++;
        if (idx == 10*CPB - 1) begin
          active = 0;
          dec_q.push_back(b);
          low_q.push_back(lows);
        end
      end
    end
  end

  task automatic clear_dec();
    dec_q.delete(); low_q.delete(); start_q.delete();
  endtask

  // Offer one byte and hold it until accepted (called and returns at negedge).
  task automatic send(input logic [7:0] b, output int acc);
    bit r;
    bit ok;
    ok = 0; acc = -1;
    in_data = b; in_valid = 1'b1;
    for (int n = 0; n < 500 && !ok; n++) begin
      r = in_ready;
      @(negedge clk);
      if (r) begin ok = 1; acc = cyc; end
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: byte %02h never accepted", b);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({tx, in_ready, busy} !== 3'b110) begin
      n_fail++; $display("FAIL reset_held: tx/in_ready/busy=%b expected 110", {tx, in_ready, busy});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({tx, in_ready, busy} !== 3'b110) begin
      n_fail++; $display("FAIL reset_released: tx/in_ready/busy=%b expected 110", {tx, in_ready, busy});
    end
  endtask

  task automatic test_single();
    int t0;
    logic [9:0] frame;
    clear_dec();
    frame = {1'b1, 8'h41, 1'b0};
    send(8'h41, t0);
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_after_push: in_ready=%b busy=%b expected 1 1", in_ready, busy);
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 0) @(negedge clk); else repeat (CPB) @(negedge clk);
      n_tests++;
      if (tx !== frame[k] || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL single_bit%0d: tx=%b expected %b (in_ready=%b)", k, tx, frame[k], in_ready);
      end
    end
    while (cyc < t0 + 10*CPB) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || tx !== 1'b1) begin
      n_fail++; $display("FAIL single_stop_end: busy=%b tx=%b expected 1 1", busy, tx);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || tx !== 1'b1 || cyc != t0 + 10*CPB + 1) begin
      n_fail++; $display("FAIL single_busy_fall: busy=%b tx=%b at cycle +%0d expected 0 1 at +%0d",
                         busy, tx, cyc - t0, 10*CPB + 1);
    end
    n_tests++;
    if (dec_q.size() != 1 || dec_q[0] !== 8'h41) begin
      n_fail++; $display("FAIL single_decode: got %0d bytes first %02h expected 41", dec_q.size(), dec_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    logic [7:0] exp[2];
    exp[0] = 8'h48; exp[1] = 8'h5A;
    clear_dec();
    send(exp[0], t0);
    send(exp[1], t1);
    n_tests++;
    if (t1 != t0 + 1) begin
      n_fail++; $display("FAIL b2b_accept: second push at +%0d expected +1", t1 - t0);
    end
    wait_idle(200);
    n_tests++;
    if (dec_q.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: decoded %0d expected 2", dec_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (i >= dec_q.size() || dec_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL b2b_byte%0d: got %02h expected %02h", i, dec_q[i], exp[i]);
      end
    end
    n_tests++;
    if (start_q.size() != 2 || start_q[0] != t0 + 1 || start_q[1] != t0 + 1 + 10*CPB) begin
      n_fail++; $display("FAIL b2b_gap: starts at +%0d,+%0d expected +1,+%0d",
                         start_q[0] - t0, start_q[1] - t0, 1 + 10*CPB);
    end
  endtask

  task automatic test_capacity();
    int acc[7];
    int idx;
    bit r;
    clear_dec();
    idx = 0;
    in_data = 8'h01; in_valid = 1'b1;
    for (int c = 0; c < 400 && idx < 7; c++) begin
      r = in_ready;
      @(negedge clk);
      if (r) begin acc[idx] = cyc; idx++; in_data = 8'(idx + 1); end
    end
    in_valid = 1'b0;
    n_tests++;
    if (idx != 7) begin
      n_fail++; $display("FAIL cap_accepted: %0d accepted expected 7", idx);
    end
    // 1 in flight + FD buffered back to back, then one per completed frame.
    for (int i = 1; i < 7 && i < idx; i++) begin
      int want;
      want = (i <= FD) ? i : (i - FD) * 10*CPB + 2;
      n_tests++;
      if (acc[i] - acc[0] != want) begin
        n_fail++; $display("FAIL cap_accept%0d: at +%0d expected +%0d", i, acc[i] - acc[0], want);
      end
    end
    wait_idle(600);
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (i >= dec_q.size() || dec_q[i] !== 8'(i + 1)) begin
        n_fail++; $display("FAIL cap_byte%0d: got %02h expected %02h", i, dec_q[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_reset_midframe();
    int t0, t1, t2, lows;
    logic [7:0] x;
    x = 8'($urandom) & 8'hF7;
    send(x, t0);
    send(8'($urandom), t1);
    send(8'($urandom), t2);
    while (cyc < t0 + 1 + 4*CPB + 1) @(negedge clk);
    n_tests++;
    if (tx !== x[3] || busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_before: tx=%b busy=%b expected %b 1", tx, busy, x[3]);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({tx, in_ready, busy} !== 3'b110) begin
      n_fail++; $display("FAIL rstmid_async: tx/in_ready/busy=%b expected 110", {tx, in_ready, busy});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_dec();
    lows = 0;
    for (int i = 0; i < 30*CPB; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_tests++;
    if (lows != 0 || dec_q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_stale: low samples %0d frames %0d busy=%b expected 0 0 0",
                         lows, dec_q.size(), busy);
    end
  endtask

  task automatic test_edge_patterns();
    int t;
    logic [7:0] pat[3];
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h7F;
    clear_dec();
    for (int i = 0; i < 3; i++) send(pat[i], t);
    wait_idle(400);
    for (int i = 0; i < 3; i++) begin
      int want_low;
      want_low = CPB * (1 + 8 - $countones(pat[i]));
      n_tests++;
      if (i >= dec_q.size() || dec_q[i] !== pat[i] || low_q[i] != want_low) begin
        n_fail++; $display("FAIL edge_%02h: decoded %02h low cycles %0d expected %02h %0d",
                           pat[i], dec_q[i], low_q[i], pat[i], want_low);
      end
    end
  endtask

  task automatic test_push_pop_same_edge();
    int t0, t;
    logic [7:0] exp[6];
    for (int i = 0; i < 6; i++) exp[i] = 8'($urandom);
    clear_dec();
    send(exp[0], t0);
    for (int i = 1; i < 4; i++) send(exp[i], t);
    while (cyc < t0 + 10*CPB) @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL pp_before: in_ready=%b expected 1", in_ready);
    end
    // Present the byte so it lands on the edge where the stop bit ends.
    in_data = exp[4]; in_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || cyc != t0 + 10*CPB + 1) begin
      n_fail++; $display("FAIL pp_same_edge: in_ready=%b expected 1", in_ready);
    end
    in_data = exp[5];
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL pp_fill: in_ready=%b expected 0", in_ready);
    end
    wait_idle(600);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (i >= dec_q.size() || dec_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL pp_byte%0d: got %02h expected %02h", i, dec_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_random();
    int t;
    logic [7:0] exp[$];
    clear_dec();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp.push_back(b);
      send(b, t);
      repeat ($urandom_range(0, 45)) @(negedge clk);
    end
    wait_idle(1000);
    n_tests++;
    if (dec_q.size() != exp.size() || frame_err != 0) begin
      n_fail++; $display("FAIL rand_count: decoded %0d framing errors %0d expected %0d 0",
                         dec_q.size(), frame_err, exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_tests++;
      if (i >= dec_q.size() || dec_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL rand_byte%0d: got %02h expected %02h", i, dec_q[i], exp[i]);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; frame_err = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_capacity();
    test_reset_midframe();
    test_edge_patterns();
    test_push_pop_same_edge();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_byte.md
Name: uart_tx_byte

Overview:
- Serializing output stage that sits directly downstream of the ASCII case converter.
- Accepts 8-bit characters over a valid/ready handshake and buffers them in a 4-entry FIFO.
- Transmits each character on a single line as an 8N1 UART frame: start bit, 8 data bits LSB first, stop bit.
- Lets the converted character stream leave the chip at a fixed baud rate.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit. Legal range 2..65535.
- FIFO_DEPTH, 4, input buffer entries. Power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  8  character to send; sampled when in_valid && in_ready.
- in_valid  input  1  upstream has a character on in_data.
- in_ready  output  1  block can accept a character this cycle.
- tx  output  1  serial line, idles high.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.

Behaviour:
- Reset (async assert, synchronous release):
  - tx=1, in_ready=1, busy=0.
  - FIFO empty, FSM in IDLE, bit and baud counters cleared.
  - Reset during a frame aborts it immediately: tx goes high with no further edge required, and buffered bytes are discarded.
- Input handshake:
  - in_ready = !fifo_full, driven combinationally from registered FIFO state.
  - Push occurs when in_valid && in_ready at a rising edge.
  - in_data must be held stable while in_valid=1 && in_ready=0. The block never drops or duplicates a byte.
- FIFO:
  - Circular, with read/write pointers plus a count.
  - A push and a pop on the same edge leaves count unchanged.
  - A push while full cannot occur, because in_ready is 0.
  - A pop while empty never occurs.
- FSM states: IDLE, START, DATA, STOP. tx is a registered output.
  - IDLE: tx=1. If the FIFO is non-empty, pop its head into an 8-bit shift register, clear the baud counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - Wraps to 0 on each bit boundary.
- Latency and timing:
  - A byte pushed at edge N into an empty FIFO while IDLE is popped at edge N+1.
  - tx falls after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Capacity:
  - While a frame is transmitting, up to FIFO_DEPTH further bytes are accepted. The in-flight byte is held in the shift register, not in the FIFO.
- busy = (state != IDLE) || fifo_count != 0.
  - busy rises the cycle after the first push.
  - busy falls the cycle after the last stop bit ends with the FIFO empty.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. After reset, push 0x41 ('A') once:
   - in_ready stays 1.
   - tx sampled every 4 cycles from 1 cycle after the push reads 0,1,0,0,0,0,0,1,0,1.
   - tx returns high, and busy drops at cycle 41.
2. Push 0x48 then 0x5A on consecutive cycles:
   - Two frames totalling 80 cycles with no idle-high gap between the first stop bit and the second start bit.
   - Decoded bytes are 0x48, 0x5A in order.
3. Hold in_valid=1 with bytes 0x01..0x07 continuously:
   - Exactly 5 are accepted (1 in flight + 4 buffered), then in_ready=0.
   - One further byte is accepted per completed frame.
   - All 7 are decoded in order.
4. Assert rst mid-frame (during DATA bit 3) with 2 bytes buffered:
   - tx=1 within the same timestep, without waiting for a clock edge.
   - in_ready=1, busy=0.
   - After release, no stale bytes are transmitted.
5. Edge patterns 0x00, 0xFF, 0x7F:
   - The line decodes correctly.
   - 0xFF frame: tx low only during the start bit.
   - 0x00 frame: tx low for 9 bit-times.
6. Push coincident with a pop at the STOP end while the FIFO is full-1:
   - Count unchanged, in_ready stays 1.
   - No byte is lost or duplicated; verify order via the decoder.
